uart_rx_cfg: RTL

UART_RX_CFG -- requirements
Module: uart_rx_cfg

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_baud_cnt.sv | 32 +++
 rtl/uart_rx_cfg.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver: FSM state encodings,
// legal parameter bounds and the baud counter width.
package uart_pkg;

    localparam int DATA_BITS_MIN = 5;
    localparam int DATA_BITS_MAX = 9;
    localparam int BAUD_DIV_MIN  = 4;
    localparam int BAUD_DIV_MAX  = 4095;
    localparam int STOP_BITS_MIN = 1;
    localparam int STOP_BITS_MAX = 2;

    localparam int CNT_W = 12;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_START  = 3'd1;
    localparam state_t ST_DATA   = 3'd2;
    localparam state_t ST_PARITY = 3'd3;
    localparam state_t ST_STOP   = 3'd4;

    function automatic bit cfg_ok(input int data_bits, input int baud_div, input int stop_bits);
        return (data_bits >= DATA_BITS_MIN) && (data_bits <= DATA_BITS_MAX) &&
               (baud_div  >= BAUD_DIV_MIN)  && (baud_div  <= BAUD_DIV_MAX)  &&
               ((baud_div % 2) == 0) &&
               (stop_bits >= STOP_BITS_MIN) && (stop_bits <= STOP_BITS_MAX);
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: held at zero by clr, pulses tick on the last cycle of a
// full (BAUD_DIV) or half (BAUD_DIV/2) bit period and then wraps.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 44
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic half,
    output logic tick
);

    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == (half ? HALF_LAST : FULL_LAST));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: start-bit qualification, LSB-first data, optional
// parity, one or two stop bits, and a ready/error/overrun handshake.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int BAUD_DIV   = 44,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RX,
    input  logic                 clr_rdy,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rdy,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    if (!cfg_ok(DATA_BITS, BAUD_DIV, STOP_BITS)) begin : g_bad_cfg
        $error("uart_rx_cfg: illegal parameter configuration");
    end

    localparam logic       HAS_PARITY = (PARITY_EN != 0);
    localparam logic       ODD        = (PARITY_ODD != 0);
    localparam logic [3:0] LAST_DATA  = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP  = 4'(STOP_BITS - 1);

    logic                 sync1;
    logic                 sync2;
    logic                 sync3;
    logic                 strt;
    state_t               state;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 par_bit;
    logic                 stop_bad;
    logic                 tick;
    logic                 done;
    logic                 par_mismatch;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            sync3 <= 1'b1;
        end else begin
            sync1 <= RX;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign strt = !sync2 && sync3;

    // Counter is parked at zero in IDLE so START begins a clean half-bit wait.
    uart_baud_cnt #(
        .BAUD_DIV(BAUD_DIV)
    ) u_baud (
        .clk (clk),
        .rst (rst),
        .clr (state == ST_IDLE),
        .half(state == ST_START),
        .tick(tick)
    );

    assign done         = (state == ST_STOP) && tick && (bit_cnt == LAST_STOP);
    assign par_mismatch = HAS_PARITY && (((^shift_reg) ^ ODD) != par_bit);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            bit_cnt   <= 4'd0;
            shift_reg <= '0;
            par_bit   <= 1'b0;
            stop_bad  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (strt) begin
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        bit_cnt <= 4'd0;
                        state   <= sync2 ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        shift_reg <= {sync2, shift_reg[DATA_BITS-1:1]};
                        if (bit_cnt == LAST_DATA) begin
                            bit_cnt  <= 4'd0;
                            stop_bad <= 1'b0;
                            state    <= HAS_PARITY ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        par_bit <= sync2;
                        state   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (!sync2) begin
                            stop_bad <= 1'b1;
                        end
                        if (bit_cnt == LAST_STOP) begin
                            state <= ST_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A completing frame wins over a same-cycle clr_rdy and never counts as overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data    <= '0;
            rdy        <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else if (done) begin
            rx_data    <= shift_reg;
            rdy        <= 1'b1;
            parity_err <= par_mismatch;
            frame_err  <= stop_bad | !sync2;
            overrun    <= clr_rdy ? 1'b0 : (overrun | rdy);
        end else if (clr_rdy) begin
            rdy        <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end
    end

endmodule
